// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA resolution, sprite constants, pixel bundle type
//               and a clipping-safe span test.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int          H_ACTIVE        = 1024;
    localparam int          V_ACTIVE        = 768;
    localparam int          SPRITE_W        = 64;
    localparam int          SPRITE_H        = 32;
    localparam logic [11:0] TRANSPARENT_RGB = 12'h000;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    // Widened to 12 bits so start+size cannot wrap past the screen edge.
    function automatic logic in_span(
        input logic [10:0] coord,
        input logic [10:0] start,
        input logic [11:0] size
    );
        logic [11:0] w_c;
        logic [11:0] w_s;
        w_c = {1'b0, coord};
        w_s = {1'b0, start};
        return (w_c >= w_s) && (w_c < (w_s + size));
    endfunction

endpackage

`default_nettype wire

// File: rtl/draw_invader_if.sv
// ============================================================================
// Module      : draw_invader_if
// Description : VGA pixel stream bundle (counts, timing, colour).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface draw_invader_if;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport slave (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

endinterface

`default_nettype wire

// File: rtl/draw_invader_delay.sv
// ============================================================================
// Module      : delay
// Description : Fixed-latency register pipeline, WIDTH bits by CLK_DEL stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay #(
    parameter int WIDTH   = 1,
    parameter int CLK_DEL = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] i_din,
    output logic      [WIDTH-1:0] o_dout
);

    import vga_pkg::*;

    generate
        if (CLK_DEL == 0) begin : g_passthrough
            assign o_dout = i_din;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [CLK_DEL];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < CLK_DEL; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_din;
                    for (int i = 1; i < CLK_DEL; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_dout = r_stage[CLK_DEL-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/draw_invader.sv
// ============================================================================
// Module      : draw_invader
// Description : Composites a 64x32 ROM sprite onto a VGA stream, 3-clk latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module draw_invader #(
    parameter int          SPRITE_W        = vga_pkg::SPRITE_W,
    parameter int          SPRITE_H        = vga_pkg::SPRITE_H,
    parameter logic [11:0] TRANSPARENT_RGB = vga_pkg::TRANSPARENT_RGB
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    draw_invader_if.slave    vga_in,
    draw_invader_if.master   vga_out,
    input  wire logic [10:0] xpos,
    input  wire logic [10:0] ypos,
    input  wire logic        alive,
    output logic      [11:0] rom_address,
    input  wire logic [11:0] rom_rgb
);

    import vga_pkg::*;

    localparam int PIPE_W = $bits(vga_t) + 1;

    logic              r_vblnk_q;
    logic [10:0]       r_xl;
    logic [10:0]       r_yl;
    logic              r_al;
    logic              w_vblnk_rise;
    logic              w_in_box;
    logic [5:0]        w_dx;
    logic [5:0]        w_dy;
    vga_t              w_pix_in;
    logic [PIPE_W-1:0] w_pipe_in;
    logic [PIPE_W-1:0] w_pipe_d2;
    vga_t              w_pix_d2;
    logic              w_in_box_d2;
    vga_t              r_pix_out;
    logic [11:0]       r_rom_address;

    // Sprite position is sampled once per frame so mid-frame moves tear nothing.
    assign w_vblnk_rise = vga_in.vblnk & ~r_vblnk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vblnk_q <= 1'b0;
            r_xl      <= '0;
            r_yl      <= '0;
            r_al      <= 1'b0;
        end else begin
            r_vblnk_q <= vga_in.vblnk;
            if (w_vblnk_rise) begin
                r_xl <= xpos;
                r_yl <= ypos;
                r_al <= alive;
            end
        end
    end

    assign w_in_box = r_al & ~vga_in.hblnk & ~vga_in.vblnk
                    & in_span(vga_in.hcount, r_xl, 12'(SPRITE_W))
                    & in_span(vga_in.vcount, r_yl, 12'(SPRITE_H));

    // Only the low six offset bits address the 64x32 ROM.
    assign w_dx = vga_in.hcount[5:0] - r_xl[5:0];
    assign w_dy = vga_in.vcount[5:0] - r_yl[5:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_address <= '0;
        end else begin
            r_rom_address <= {w_dy, w_dx};
        end
    end

    assign rom_address = r_rom_address;

    always_comb begin
        w_pix_in        = '0;
        w_pix_in.hcount = vga_in.hcount;
        w_pix_in.vcount = vga_in.vcount;
        w_pix_in.hsync  = vga_in.hsync;
        w_pix_in.vsync  = vga_in.vsync;
        w_pix_in.hblnk  = vga_in.hblnk;
        w_pix_in.vblnk  = vga_in.vblnk;
        w_pix_in.rgb    = vga_in.rgb;
    end

    assign w_pipe_in = {w_pix_in, w_in_box};

    delay #(
        .WIDTH   (PIPE_W),
        .CLK_DEL (2)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_din  (w_pipe_in),
        .o_dout (w_pipe_d2)
    );

    assign w_pix_d2    = vga_t'(w_pipe_d2[PIPE_W-1:1]);
    assign w_in_box_d2 = w_pipe_d2[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_out <= '0;
        end else begin
            r_pix_out <= w_pix_d2;
            if (w_in_box_d2 && (rom_rgb != TRANSPARENT_RGB)) begin
                r_pix_out.rgb <= rom_rgb;
            end
        end
    end

    assign vga_out.hcount = r_pix_out.hcount;
    assign vga_out.vcount = r_pix_out.vcount;
    assign vga_out.hsync  = r_pix_out.hsync;
    assign vga_out.vsync  = r_pix_out.vsync;
    assign vga_out.hblnk  = r_pix_out.hblnk;
    assign vga_out.vblnk  = r_pix_out.vblnk;
    assign vga_out.rgb    = r_pix_out.rgb;

endmodule

`default_nettype wire

// File: tb/tb_draw_invader.sv
// ============================================================================
// Module      : tb_draw_invader
// Description : Scoreboard bench for draw_invader with a registered ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_draw_invader;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic        alive;
    logic [11:0] rom_address;
    logic [11:0] rom_rgb;
    logic [11:0] rom_mem [4096];

    draw_invader_if vin ();
    draw_invader_if vout ();

    draw_invader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vga_in      (vin),
        .vga_out     (vout),
        .xpos        (xpos),
        .ypos        (ypos),
        .alive       (alive),
        .rom_address (rom_address),
        .rom_rgb     (rom_rgb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_rgb <= rom_mem[rom_address];

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        q[$];
    logic [2:0]  tb_v     = 3'b000;
    logic        in_valid = 1'b0;
    int          hit_cnt, hit_hmin, hit_hmax, hit_vmin, hit_vmax;
    logic [11:0] cap_rgb;

    // Frame-latch model: state as seen by the DUT before the sampling edge.
    logic [10:0] m_xl = '0;
    logic [10:0] m_yl = '0;
    logic        m_al = 1'b0;
    logic        m_pvb = 1'b0;

    exp_t        mon_e;
    logic [37:0] mon_got;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            tb_v = 3'b000;
            q.delete();
        end else begin
            tb_v = {tb_v[1:0], in_valid};
            if (tb_v[2]) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL scoreboard_underflow: output with no expected entry");
                end else begin
                    mon_e   = q.pop_front();
                    mon_got = {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                               vout.hblnk, vout.vblnk, vout.rgb};
                    if (mon_got !== mon_e) begin
                        $display("FAIL pixel h=%0d v=%0d: got %h, expected %h",
                                 mon_e.h, mon_e.v, mon_got, mon_e);
                    end else begin
                        n_pass++;
                    end
                    if (!mon_e.hb && !mon_e.vb && vout.rgb == 12'hF00) begin
                        hit_cnt++;
                        if (int'(mon_e.h) < hit_hmin) hit_hmin = int'(mon_e.h);
                        if (int'(mon_e.h) > hit_hmax) hit_hmax = int'(mon_e.h);
                        if (int'(mon_e.v) < hit_vmin) hit_vmin = int'(mon_e.v);
                        if (int'(mon_e.v) > hit_vmax) hit_vmax = int'(mon_e.v);
                    end
                    if (mon_e.h == 11'd105 && mon_e.v == 11'd50) cap_rgb = vout.rgb;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_hits();
        hit_cnt  = 0;
        hit_hmin = 9999;
        hit_hmax = -1;
        hit_vmin = 9999;
        hit_vmax = -1;
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v,
                         input logic hb, input logic vb, input logic [11:0] rgb);
        exp_t e;
        logic inb;
        int   hi, vi, xi, yi;
        logic [5:0] dx, dy;
        logic [11:0] romv;
        @(negedge clk);
        vin.hcount = h;
        vin.vcount = v;
        vin.hsync  = h[4];
        vin.vsync  = v[1];
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = rgb;
        in_valid   = 1'b1;
        hi = int'(h); vi = int'(v); xi = int'(m_xl); yi = int'(m_yl);
        inb  = m_al && !hb && !vb && hi >= xi && hi < xi + 64 && vi >= yi && vi < yi + 32;
        dx   = 6'(hi - xi);
        dy   = 6'(vi - yi);
        romv = rom_mem[{dy, dx}];
        e.h = h; e.v = v; e.hs = h[4]; e.vs = v[1]; e.hb = hb; e.vb = vb;
        e.rgb = (inb && romv != 12'h000) ? romv : rgb;
        q.push_back(e);
        if (vb && !m_pvb) begin
            m_xl = xpos;
            m_yl = ypos;
            m_al = alive;
        end
        m_pvb = vb;
    endtask

    task automatic vblank();
        drive(11'd1024, 11'd767, 1'b1, 1'b0, 12'h000);
        for (int i = 0; i < 4; i++) drive(11'(1024 + i), 11'd768, 1'b1, 1'b1, 12'h123);
        drive(11'd1024, 11'd0, 1'b1, 1'b0, 12'h000);
    endtask

    task automatic draw(input int v0, input int v1, input int h0, input int h1,
                        input logic [11:0] rgb);
        for (int v = v0; v <= v1; v++) begin
            for (int h = h0; h <= h1; h++) drive(11'(h), 11'(v), 1'b0, 1'b0, rgb);
            drive(11'd1030, 11'(v), 1'b1, 1'b0, 12'h000);
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 4; i++) drive(11'd1040, 11'd700, 1'b1, 1'b0, 12'h000);
    endtask

    task automatic test_reset();
        vin.hcount = 11'd120; vin.vcount = 11'd60; vin.hsync = 1'b1; vin.vsync = 1'b1;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'hABC;
        xpos = 11'd100; ypos = 11'd50; alive = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb} !== 38'd0)
            $display("FAIL reset_outputs: got %h, expected 0",
                     {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb});
        else n_pass++;
        n_checks++;
        if (rom_address !== 12'h000) $display("FAIL reset_rom_address: got %h, expected 000", rom_address);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        // No vblank rise yet: sprite must remain hidden.
        clear_hits();
        draw(50, 53, 96, 167, 12'h0A5);
        settle();
        n_checks++;
        if (hit_cnt !== 0) $display("FAIL invisible_before_vblank: got %0d hits, expected 0", hit_cnt);
        else n_pass++;
    endtask

    task automatic test_basic();
        xpos = 11'd100; ypos = 11'd50; alive = 1'b1;
        vblank();
        clear_hits();
        draw(48, 83, 96, 167, 12'h0A5);
        settle();
        n_checks++;
        if (hit_cnt !== 2048) $display("FAIL basic_count: got %0d, expected 2048", hit_cnt); else n_pass++;
        n_checks++;
        if (hit_hmin !== 100 || hit_hmax !== 163)
            $display("FAIL basic_hrange: got %0d..%0d, expected 100..163", hit_hmin, hit_hmax);
        else n_pass++;
        n_checks++;
        if (hit_vmin !== 50 || hit_vmax !== 81)
            $display("FAIL basic_vrange: got %0d..%0d, expected 50..81", hit_vmin, hit_vmax);
        else n_pass++;
    endtask

    task automatic test_transparent();
        rom_mem[5] = 12'h000;
        vblank();
        cap_rgb = 12'hFFF;
        for (int h = 100; h <= 110; h++) begin
            drive(11'(h), 11'd50, 1'b0, 1'b0, 12'h00F);
            if (h == 106) begin
                @(posedge clk);
                #1;
                n_checks++;
                if (rom_address !== 12'h006) $display("FAIL rom_address_h106: got %h, expected 006", rom_address);
                else n_pass++;
            end
        end
        settle();
        n_checks++;
        if (cap_rgb !== 12'h00F) $display("FAIL transparent_pixel: got %h, expected 00F", cap_rgb);
        else n_pass++;
        rom_mem[5] = 12'hF00;
    endtask

    task automatic test_right_edge();
        xpos = 11'd1000; ypos = 11'd50; alive = 1'b1;
        vblank();
        clear_hits();
        draw(50, 51, 0, 1023, 12'h0A5);
        settle();
        n_checks++;
        if (hit_cnt !== 48) $display("FAIL edge_count: got %0d, expected 48", hit_cnt); else n_pass++;
        n_checks++;
        if (hit_hmin !== 1000 || hit_hmax !== 1023)
            $display("FAIL edge_hrange: got %0d..%0d, expected 1000..1023", hit_hmin, hit_hmax);
        else n_pass++;
    endtask

    task automatic test_move_midframe();
        xpos = 11'd100; ypos = 11'd50; alive = 1'b1;
        vblank();
        clear_hits();
        draw(50, 60, 96, 370, 12'h0A5);
        xpos = 11'd300;
        draw(61, 81, 96, 370, 12'h0A5);
        settle();
        n_checks++;
        if (hit_cnt !== 2048 || hit_hmin !== 100 || hit_hmax !== 163)
            $display("FAIL move_current: got %0d hits at %0d..%0d, expected 2048 at 100..163",
                     hit_cnt, hit_hmin, hit_hmax);
        else n_pass++;
        vblank();
        clear_hits();
        draw(50, 81, 96, 370, 12'h0A5);
        settle();
        n_checks++;
        if (hit_cnt !== 2048 || hit_hmin !== 300 || hit_hmax !== 363)
            $display("FAIL move_next: got %0d hits at %0d..%0d, expected 2048 at 300..363",
                     hit_cnt, hit_hmin, hit_hmax);
        else n_pass++;
    endtask

    task automatic test_dead();
        xpos = 11'd100; ypos = 11'd50; alive = 1'b0;
        vblank();
        clear_hits();
        draw(48, 83, 96, 167, 12'h3C7);
        settle();
        n_checks++;
        if (hit_cnt !== 0) $display("FAIL dead_hits: got %0d, expected 0", hit_cnt); else n_pass++;
    endtask

    task automatic test_offscreen();
        xpos = 11'd1100; ypos = 11'd50; alive = 1'b1;
        vblank();
        clear_hits();
        draw(50, 51, 0, 1023, 12'h0A5);
        settle();
        n_checks++;
        if (hit_cnt !== 0) $display("FAIL offscreen_x: got %0d hits, expected 0", hit_cnt); else n_pass++;
        xpos = 11'd100; ypos = 11'd800;
        vblank();
        clear_hits();
        draw(48, 83, 96, 167, 12'h0A5);
        settle();
        n_checks++;
        if (hit_cnt !== 0) $display("FAIL offscreen_y: got %0d hits, expected 0", hit_cnt); else n_pass++;
    endtask

    task automatic test_midreset();
        xpos = 11'd100; ypos = 11'd50; alive = 1'b1;
        vblank();
        draw(50, 55, 96, 167, 12'h0A5);
        drive(11'd120, 11'd56, 1'b0, 1'b0, 12'h0A5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        m_xl = '0; m_yl = '0; m_al = 1'b0; m_pvb = 1'b0;
        #1;
        n_checks++;
        if ({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb} !== 38'd0)
            $display("FAIL midreset_outputs: got %h, expected 0",
                     {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb});
        else n_pass++;
        n_checks++;
        if (rom_address !== 12'h000) $display("FAIL midreset_rom_address: got %h, expected 000", rom_address);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_hits();
        draw(56, 81, 96, 167, 12'h0A5);
        settle();
        n_checks++;
        if (hit_cnt !== 0) $display("FAIL midreset_no_sprite: got %0d hits, expected 0", hit_cnt); else n_pass++;
        vblank();
        clear_hits();
        draw(50, 81, 96, 167, 12'h0A5);
        settle();
        n_checks++;
        if (hit_cnt !== 2048) $display("FAIL midreset_next_frame: got %0d hits, expected 2048", hit_cnt);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 12'hF00;
        rom_rgb = 12'h000;
        clear_hits();
        cap_rgb = 12'h000;
        test_reset();
        test_basic();
        test_transparent();
        test_right_edge();
        test_move_midframe();
        test_dead();
        test_offscreen();
        test_midreset();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/draw_invader.md
DRAW_INVADER -- requirements
Module: draw_invader

Interface
REQ-001 Parameter SPRITE_W, default 64, sprite width in pixels; the block is only defined for 64.
REQ-002 Parameter SPRITE_H, default 32, sprite height in pixels; the block is only defined for 32.
REQ-003 Parameter TRANSPARENT_RGB, default 12'h000, the sprite colour that is not drawn.
REQ-004 clk  in  1  pixel clock; the only clock.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 hcount_in, vcount_in  in  11 each  pixel coordinates of the incoming VGA stream.
REQ-007 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  incoming VGA timing.
REQ-008 rgb_in  in  12  background colour.
REQ-009 xpos, ypos  in  11 each  sprite top-left corner, in screen coordinates.
REQ-010 alive  in  1  sprite visible when 1.
REQ-011 rom_address  out  12  address to the sprite ROM, formed as {dy[5:0], dx[5:0]}.
REQ-012 rom_rgb  in  12  ROM data; it is valid one clk after rom_address.
REQ-013 hcount_out, vcount_out  out  11 each  delayed coordinates.
REQ-014 hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing.
REQ-015 rgb_out  out  12  composited colour.

Function
REQ-016 Frame latch: the block SHALL capture xpos, ypos and alive into internal registers (xl, yl, al) on the clk edge where vblnk_in goes from 0 to 1; between those edges the registers SHALL hold their value.
REQ-017 In-box (stage 1): in_box SHALL equal al AND NOT hblnk_in AND NOT vblnk_in AND xl <= hcount_in < xl+SPRITE_W AND yl <= vcount_in < yl+SPRITE_H.
REQ-018 The additions in REQ-017 SHALL be evaluated at 12-bit width, so a sprite that crosses the right or bottom edge clips and never wraps.
REQ-019 rom_address SHALL be registered at edge 1 as {(vcount_in-yl)[5:0], (hcount_in-xl)[5:0]}; when in_box is 0 its value is don't-care.
REQ-020 All timing, count and rgb_in signals, plus in_box, SHALL be delayed 2 clk so they align with rom_rgb.
REQ-021 Output stage, registered at edge 3: rgb_out SHALL equal rom_rgb when in_box_d2 is 1 and rom_rgb != TRANSPARENT_RGB, and rgb_in_d2 otherwise.
REQ-022 Every *_out signal SHALL equal its *_in counterpart delayed exactly 3 clk, apart from rgb_out substitution under REQ-021.
REQ-023 Changes to xpos, ypos or alive during active video SHALL NOT affect the current frame.
REQ-024 xpos >= 1024 or ypos >= 768 SHALL result in no pixels being drawn and no error.

Reset
REQ-025 While rst_n is 0, all pipeline registers, rom_address, xl, yl, al and every output SHALL be 0 asynchronously.
REQ-026 After rst_n deasserts, the sprite SHALL stay invisible until the first vblnk_in rising edge.
REQ-027 A reset in mid-frame SHALL discard all pipeline contents, with no stale pixel emitted.

Structure
REQ-028 SPRITE_W, SPRITE_H, TRANSPARENT_RGB and the VGA resolution constants SHALL reside in the shared vga_pkg.
REQ-029 The fixed-latency signal delay SHALL be a parameterised sub-module named delay (WIDTH, CLK_DEL).
REQ-030 The ROM SHALL be instantiated outside draw_invader.

Verification
REQ-031 xpos=100, ypos=50, alive=1, ROM all 12'hF00, vblnk pulse -> rgb_out=F00 exactly for h 100..163 and v 50..81, with output latency 3.
REQ-032 ROM pixel (dy=0, dx=5)=TRANSPARENT_RGB, rgb_in=12'h00F -> at h=105, v=50 rgb_out=00F; rom_address at h=106 equals 12'h006.
REQ-033 xpos=1000 -> pixels drawn for h 1000..1023 only, and no sprite pixel appears at h 0..39.
REQ-034 xpos changed from 100 to 300 mid-frame -> current frame drawn at 100 and next frame at 300.
REQ-035 alive=0 latched -> rgb_out == rgb_in delayed 3 clk for a whole frame.
REQ-036 rst_n pulsed low inside the sprite region -> all outputs 0 immediately; after release no sprite until next vblnk rise.
